// File: rtl/wavetable_loader.sv
// Byte-stream loader that assembles little-endian 16-bit samples and writes one full
// wavetable into the shared RAM bank. Optional trailing checksum word: define CHECKSUM_EN.
module wavetable_loader #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned TBL_W  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic [TBL_W-1:0]        table_sel,
    input  logic [7:0]              rx_data,
    input  logic                    rx_valid,
    output logic                    rx_ready,
    output logic                    we,
    output logic [TBL_W+ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0]       wdata,
    output logic                    busy,
    output logic                    done,
    output logic                    error
);

    localparam int unsigned AW    = TBL_W + ADDR_W;
    localparam int unsigned CK_W  = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LO,
        S_HI,
        S_WR,
        S_DONE
`ifdef CHECKSUM_EN
        ,
        S_CK_LO,
        S_CK_HI
`endif
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   index_q, index_d;
    logic [TBL_W-1:0]    tbl_q, tbl_d;
    logic [7:0]          lo_q, lo_d;
    logic [AW-1:0]       waddr_q, waddr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                rx_ready_q, rx_ready_d;
    logic                we_q, we_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                xfer;
    logic                last_idx;

`ifdef CHECKSUM_EN
    logic [CK_W-1:0]     sum_q, sum_d;
    logic [7:0]          ck_lo_q, ck_lo_d;
    logic                error_q, error_d;
`endif

    assign xfer     = rx_valid & rx_ready_q;
    assign last_idx = (index_q == {ADDR_W{1'b1}});

    // Next-state and datapath; abort overrides every transition and holds all registers.
    always_comb begin
        state_d = state_q;
        index_d = index_q;
        tbl_d   = tbl_q;
        lo_d    = lo_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
`ifdef CHECKSUM_EN
        sum_d   = sum_q;
        ck_lo_d = ck_lo_q;
        error_d = error_q;
`endif
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        tbl_d   = table_sel;
                        index_d = '0;
`ifdef CHECKSUM_EN
                        sum_d   = '0;
                        error_d = 1'b0;
`endif
                        state_d = S_LO;
                    end
                end
                S_LO: begin
                    if (xfer) begin
                        lo_d    = rx_data;
                        state_d = S_HI;
                    end
                end
                S_HI: begin
                    if (xfer) begin
                        waddr_d = {tbl_q, index_q};
                        wdata_d = DATA_W'({rx_data, lo_q});
                        state_d = S_WR;
                    end
                end
                S_WR: begin
`ifdef CHECKSUM_EN
                    sum_d = sum_q + CK_W'(wdata_q);
`endif
                    if (last_idx) begin
`ifdef CHECKSUM_EN
                        state_d = S_CK_LO;
`else
                        state_d = S_DONE;
`endif
                    end else begin
                        index_d = ADDR_W'(index_q + 1'b1);
                        state_d = S_LO;
                    end
                end
`ifdef CHECKSUM_EN
                S_CK_LO: begin
                    if (xfer) begin
                        ck_lo_d = rx_data;
                        state_d = S_CK_HI;
                    end
                end
                S_CK_HI: begin
                    if (xfer) begin
                        error_d = (sum_q != CK_W'({rx_data, ck_lo_q}));
                        state_d = S_DONE;
                    end
                end
`endif
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Handshake and status outputs are registered from the state being entered.
    always_comb begin
        rx_ready_d = 1'b0;
        we_d       = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        case (state_d)
            S_LO, S_HI: begin
                rx_ready_d = 1'b1;
                busy_d     = 1'b1;
            end
            S_WR: begin
                we_d   = 1'b1;
                busy_d = 1'b1;
            end
`ifdef CHECKSUM_EN
            S_CK_LO, S_CK_HI: begin
                rx_ready_d = 1'b1;
                busy_d     = 1'b1;
            end
`endif
            S_DONE:  done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            index_q    <= '0;
            tbl_q      <= '0;
            lo_q       <= '0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            rx_ready_q <= 1'b0;
            we_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            index_q    <= index_d;
            tbl_q      <= tbl_d;
            lo_q       <= lo_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            rx_ready_q <= rx_ready_d;
            we_q       <= we_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

`ifdef CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= '0;
            ck_lo_q <= '0;
            error_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            ck_lo_q <= ck_lo_d;
            error_q <= error_d;
        end
    end

    assign error = error_q;
`else
    assign error = 1'b0;
`endif

    // The RAM samples we at the edge closing WR, so an abort in that cycle must drop it.
    assign we       = we_q & ~abort;
    assign rx_ready = rx_ready_q;
    assign waddr    = waddr_q;
    assign wdata    = wdata_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_wavetable_loader.sv
// Scoreboard bench for wavetable_loader: stimulus queues expected RAM writes,
// a negedge monitor pops and compares them whenever we is seen.
`timescale 1ns/1ps
module tb_wavetable_loader;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned TBL_W  = 2;
    localparam int unsigned AW     = TBL_W + ADDR_W;
    localparam int unsigned N_SAMP = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [TBL_W-1:0]  table_sel = '0;
    logic [7:0]        rx_data = '0;
    logic              rx_valid = 1'b0;
    logic              rx_ready;
    logic              we;
    logic [AW-1:0]     waddr;
    logic [DATA_W-1:0] wdata;
    logic              busy;
    logic              done;
    logic              error;

    wavetable_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TBL_W(TBL_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .table_sel(table_sel), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .we(we), .waddr(waddr), .wdata(wdata),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0]     addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    wr_t  exp_q[$];
    wr_t  mon_e;
    int   n_tests = 0;
    int   n_fail = 0;
    int   done_cnt = 0;
    int   cyc = 0;
    int   last_we_cyc = -1;
    bit   gap_chk = 1'b0;
    logic exp_error = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every we pulse must match the oldest expected write.
    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (we) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_we", 32'(waddr), 32'hFFFF_FFFF);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("waddr", 32'(waddr), 32'(mon_e.addr));
                    check("wdata", 32'(wdata), 32'(mon_e.data));
                end
                if (gap_chk && last_we_cyc >= 0) check("we_spacing", 32'(cyc - last_we_cyc), 32'd3);
                last_we_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                check("error_at_done", 32'(error), 32'(exp_error));
                check("busy_at_done", 32'(busy), 32'd0);
            end
        end
    end

    function automatic logic [7:0] pattern_byte(input int mode, input int k);
        logic [31:0] kv;
        kv = 32'(k);
        if (mode == 0) return kv[7:0];
        if (mode == 1) return (k % 2 == 0) ? 8'h01 : 8'h00;
        return 8'($urandom_range(0, 255));
    endfunction

    task automatic finish_now();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "bench stopped on timeout");
    endtask

    task automatic send_byte(input logic [7:0] b, input bit rnd);
        bit xfer;
        int guard;
        xfer  = 1'b0;
        guard = 0;
        rx_data = b;
        while (!xfer) begin
            rx_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            xfer = rx_valid && rx_ready;
            @(posedge clk);
            #1;
            guard++;
            if (guard > 200) begin
                n_tests++;
                n_fail++;
                $display("FAIL send_byte_timeout: byte 0x%0h not accepted in 200 cycles", b);
                finish_now();
            end
        end
        rx_valid = 1'b0;
    endtask

    task automatic pulse_start(input logic [TBL_W-1:0] tbl);
        table_sel = tbl;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic pulse_abort();
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
    endtask

    // Reference: sample i is bytes 2i (low) and 2i+1 (high) at address {table, i}.
    task automatic load_samples(input logic [TBL_W-1:0] tbl, input int first, input int n,
                                input int mode, input bit rnd);
        logic [7:0] lo, hi;
        wr_t e;
        for (int i = first; i < first + n; i++) begin
            lo = pattern_byte(mode, 2 * i);
            hi = pattern_byte(mode, 2 * i + 1);
            e.addr = {tbl, ADDR_W'(i)};
            e.data = {hi, lo};
            exp_q.push_back(e);
            send_byte(lo, rnd);
            send_byte(hi, rnd);
        end
    endtask

    task automatic run_load(input logic [TBL_W-1:0] tbl, input int mode, input bit rnd,
                            input bit corrupt);
        int   d0;
        int   guard;
        logic [15:0] sum;
        logic [15:0] ck;
        sum = '0;
        for (int i = 0; i < int'(N_SAMP); i++)
            sum = sum + {pattern_byte(mode, 2 * i + 1), pattern_byte(mode, 2 * i)};
        d0 = done_cnt;
`ifdef CHECKSUM_EN
        exp_error = corrupt;
`else
        exp_error = 1'b0;
`endif
        pulse_start(tbl);
        load_samples(tbl, 0, int'(N_SAMP), mode, rnd);
`ifdef CHECKSUM_EN
        ck = corrupt ? sum + 16'd1 : sum;
        send_byte(ck[7:0], rnd);
        send_byte(ck[15:8], rnd);
`else
        ck = sum;
`endif
        guard = 0;
        while (done_cnt == d0 && guard < 10) begin
            @(posedge clk);
            #1;
            guard++;
        end
        repeat (3) @(posedge clk);
        #1;
        check("done_pulses", 32'(done_cnt - d0), 32'd1);
        check("busy_after_done", 32'(busy), 32'd0);
        check("writes_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        // Reset state.
        #1;
        check("rst_rx_ready", 32'(rx_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_we", 32'(we), 32'd0);
        check("rst_waddr", 32'(waddr), 32'd0);
        #20;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset mid-load after the low byte of index 100.
        pulse_start(2'd1);
        load_samples(2'd1, 0, 100, 2, 1'b1);
        send_byte(8'hA5, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_rx_ready", 32'(rx_ready), 32'd0);
        check("midrst_we", 32'(we), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_error", 32'(error), 32'd0);
        check("midrst_waddr", 32'(waddr), 32'd0);
        check("midrst_wdata", 32'(wdata), 32'd0);
        check("midrst_drained", 32'(exp_q.size()), 32'd0);
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        pulse_start(2'd0);
        load_samples(2'd0, 0, 2, 2, 1'b1);
        @(posedge clk);
        #1;
        pulse_abort();
        check("restart_drained", 32'(exp_q.size()), 32'd0);

        // start and abort together in IDLE: stay idle.
        table_sel = 2'd3;
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_busy", 32'(busy), 32'd0);
        check("start_abort_rx_ready", 32'(rx_ready), 32'd0);

        // Full table 2 load, counting bytes, back-to-back.
        gap_chk = 1'b1;
        last_we_cyc = -1;
        run_load(2'd2, 0, 1'b0, 1'b0);
        gap_chk = 1'b0;

        // Same data into table 1 with random rx_valid.
        run_load(2'd1, 0, 1'b1, 1'b0);

        // Abort during the WR cycle of index 5.
        begin
            int d0;
            d0 = done_cnt;
            pulse_start(2'd1);
            load_samples(2'd1, 0, 5, 2, 1'b1);
            send_byte(8'h12, 1'b1);
            send_byte(8'h34, 1'b1);
            pulse_abort();
            @(posedge clk);
            #1;
            check("abort_busy", 32'(busy), 32'd0);
            check("abort_rx_ready", 32'(rx_ready), 32'd0);
            check("abort_done", 32'(done_cnt - d0), 32'd0);
            check("abort_drained", 32'(exp_q.size()), 32'd0);
            pulse_start(2'd0);
            load_samples(2'd0, 0, 2, 2, 1'b0);
            @(posedge clk);
            #1;
            pulse_abort();
        end

        // start during a table-3 load with table_sel=0 is ignored.
        pulse_start(2'd3);
        load_samples(2'd3, 0, 10, 2, 1'b1);
        @(posedge clk);
        #1;
        pulse_start(2'd0);
        check("busy_start_ignored", 32'(busy), 32'd1);
        load_samples(2'd3, 10, 6, 2, 1'b1);
        @(posedge clk);
        #1;
        pulse_abort();
        check("ignored_start_drained", 32'(exp_q.size()), 32'd0);

`ifdef CHECKSUM_EN
        // All-0x0001 table: good checksum, then off-by-one checksum.
        run_load(2'd0, 1, 1'b0, 1'b0);
        check("ck_good_error", 32'(error), 32'd0);
        run_load(2'd0, 1, 1'b0, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        check("ck_bad_error_held", 32'(error), 32'd1);
        pulse_start(2'd0);
        check("ck_error_cleared", 32'(error), 32'd0);
        pulse_abort();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wavetable_loader.md
Name: wavetable_loader

Overview:
- Writer side of the waveform sample tables that the shape selectors read.
- Receives a byte stream over a valid/ready handshake and assembles little-endian 16-bit samples.
- Writes one full table of 2^ADDR_W samples into the shared wavetable RAM bank picked by table_sel.
- Sits between the host/UART byte receiver and the dual-port wavetable RAM. Sample playback reads the other RAM port.

Parameters:
ADDR_W, 12, sample index width; each table holds 2^ADDR_W samples
DATA_W, 16, sample width; fixed at 2 bytes per sample
TBL_W, 2, table select width (0 sine, 1 square, 2 saw, 3 triangle)

Ports:
Clk  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-low reset
start  in  1  single-cycle request to begin loading; honoured only in IDLE
abort  in  1  synchronous abort; returns to IDLE from any state
table_sel  in  TBL_W  target table; sampled on the accepted start
rx_data  in  8  incoming byte
rx_valid  in  1  rx_data valid
rx_ready  out  1  loader accepts a byte this cycle
we  out  1  RAM write enable, one-cycle pulse per sample
waddr  out  TBL_W+ADDR_W  RAM write address {table, index}
wdata  out  DATA_W  RAM write data {hi byte, lo byte}
busy  out  1  load in progress
done  out  1  one-cycle pulse on load completion
error  out  1  checksum mismatch flag (see Optional Feature)

Behaviour:
- Reset (Reset=0, async): state=IDLE, index=0, table reg=0. rx_ready, we, busy, done and error are 0. waddr=0, wdata=0. A partially assembled sample is discarded and never written.
- States: IDLE, LO, HI, WR, DONE (plus CK_LO, CK_HI with CHECKSUM_EN).
- IDLE:
  - rx_ready=0, busy=0.
  - start=1 latches table_sel, clears index, clears error, and goes to LO.
- LO:
  - rx_ready=1, busy=1.
  - A byte is transferred only on a cycle with rx_valid&rx_ready. That cycle latches the low byte and goes to HI.
  - Otherwise the state holds.
- HI: rx_ready=1. On transfer, latches the high byte and goes to WR.
- WR:
  - rx_ready=0.
  - we=1 for exactly this cycle, with waddr={table, index} and wdata={hi, lo}.
  - If index==2^ADDR_W-1, goes to DONE (CK_LO with CHECKSUM_EN).
  - Otherwise index+1 and goes to LO.
- DONE: done=1 for one cycle, busy=0 in this cycle, then IDLE.
- Timing:
  - Write latency is one cycle after the high-byte transfer.
  - Peak throughput is 1 sample per 3 cycles.
  - waddr/wdata are registered and stable only while we=1; they are don't-care otherwise.
- Index never wraps within a load: the write at index 4095 is the last one.
- start while busy is ignored and does not relatch table_sel.
- abort:
  - Takes priority over every transition. Next state is IDLE, with busy=0 and done=0.
  - A write pending in WR during the abort cycle is suppressed (we=0).
  - RAM contents already written stay.
- start and abort in the same IDLE cycle: abort wins, stay IDLE.
- rx_valid while rx_ready=0: the byte is not consumed. The upstream source holds it.

Optional Feature:
- Macro CHECKSUM_EN.
- Defined:
  - A 16-bit running sum (mod 2^16) of every written sample, cleared on the accepted start.
  - After the last WR, CK_LO and CK_HI accept two more bytes (little-endian checksum word).
  - Then DONE. error is set in the DONE cycle if sum != checksum word.
  - error holds until the next accepted start or reset.
  - Table writes are not undone on mismatch.
  - abort during CK_LO/CK_HI returns to IDLE with error unchanged.
- Not defined: there are no CK states and error is tied to 0.

Test Plan:
1. Reset low mid-load at index 100 after the low byte was accepted -> all outputs 0, no we pulse, and the next start restarts at index 0.
2. table_sel=2, start, 8192 bytes with byte k=k[7:0] and rx_valid always 1:
   - we pulses 4096 times, once every 3 cycles.
   - First write: waddr=0x2000, wdata=0x0100.
   - Last write: waddr=0x2FFF, wdata=0xFFFE.
   - done pulses once and busy=0 after.
3. rx_valid toggled randomly (~50%) while loading table 1:
   - write data is identical to scenario 2.
   - No byte is lost or duplicated, and we never pulses without a completed pair.
4. abort asserted in the WR cycle of index 5 -> no write for index 5, state IDLE, done stays 0. A further start with table_sel=0 writes from waddr=0x0000.
5. start pulsed at index 10 of a table-3 load with table_sel=0 -> ignored; all writes keep table bits 3 (waddr 0x300A, ...).
6. CHECKSUM_EN, all samples 0x0001:
   - Checksum bytes 0x00,0x10 -> done with error=0.
   - Checksum bytes 0x01,0x10 -> error=1, held until the next start.
